pipelined_core_fwd: RTL and testbench
=====================================

Name: pipelined_core_fwd

Overview:
- Parametrised four-stage in-order integer pipeline: Decode, Execute, Memory, Writeback.
- Successor to the team's fixed three-stage core.
- Adds valid/ready instruction intake, full operand forwarding, load-use stall interlock, a STORE path, ADDI, a hardwired-zero r0, a writeback observation port and a retire counter.
- Sits behind the instruction feeder and drives the debug/result bus.

Parameters:
- DATA_W, 32: datapath and register width; immediate sign-extended to DATA_W.
- NREGS, 32: register count, power of two, 8..32; register index = low log2(NREGS) bits of each 5-bit field.
- DMEM_DEPTH, 1024: data memory depth in DATA_W words, power of two.
- DBG_REG, 1: register index mirrored on result_out.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_in  in  32  instruction word
- instr_valid  in  1  instr_in valid
- instr_ready  out  1  core can accept; transfer when valid&ready at clk edge
- wb_valid  out  1  register-writing instruction retired this cycle
- wb_rd  out  5  destination of retiring instruction
- wb_data  out  DATA_W  value written
- result_out  out  DATA_W  registers[DBG_REG], registered
- retire_count  out  32  count of valid instructions leaving W, wraps at 2^32

Behaviour:
- Encoding: opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
- Opcodes:
  - 000000 ADD: rd=rs1+rs2
  - 000001 SUB: rd=rs1-rs2
  - 000010 LOAD: rd=mem[addr]
  - 000011 STORE: mem[addr]=reg[rd]
  - 000100 ADDI: rd=rs1+sext(imm)
  - all others: NOP (valid, no side effect)
- Address: addr=((rs1+sext(imm))>>2) mod DMEM_DEPTH (wraps silently).
- Arithmetic is modulo 2^DATA_W; no flags.
- r0 reads 0 always; writes to r0 are discarded, but wb_valid still pulses with wb_rd=0.
- Stage registers (each carries a valid bit):
  - IF/ID: loaded on handshake.
  - ID/EX: operands read from regfile.
  - EX/MEM: ALU result or address, store data.
  - MEM/WB: result or load data. The regfile write occurs at the same edge MEM/WB loads.
- Latency: instruction accepted at edge T; its regfile write and wb_* update at edge T+3.
- Synchronous memory:
  - Load data is read in M and captured into MEM/WB.
  - Store writes at the edge the instruction leaves M.
- Forwarding into EX operands (rs1, rs2, and STORE data rd), priority order:
  - EX/MEM result (non-LOAD producer, rd!=0)
  - MEM/WB result (rd!=0)
  - ID/EX captured value
- Distance-3 dependences read the updated regfile directly; no bypass needed.
- Load-use stall:
  - Condition: ID/EX holds a valid LOAD with rd!=0 and IF/ID holds a valid instruction that sources that register.
  - Action: instr_ready=0, IF/ID held, bubble inserted into ID/EX for exactly one cycle.
- instr_ready=1 whenever no stall, including when IF/ID is empty.
- instr_valid low produces a bubble; bubbles never assert wb_valid or increment retire_count.
- Reset (synchronous, may occur mid-stream):
  - All stage valids cleared; in-flight instructions dropped with no write.
  - Regfile and data memory zeroed.
  - wb_valid=0, wb_rd=0, wb_data=0, result_out=0, retire_count=0.
  - instr_ready=1 from the first cycle after reset deasserts.
- result_out updates one cycle after the write of DBG_REG.
- retire_count increments for every valid instruction leaving W, including NOP and STORE.

Test Plan:
- Reset then back-to-back ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 -> no stall; wb r1=5, r2=7, r3=12 on consecutive cycles; result_out=5 after r1 write.
- SUB r6,r1,r2 with r1=5, r2=7 -> wb_data=0xFFFFFFFE; ADDI r0,r0,9 then ADD r7,r0,r0 -> wb_rd=0 pulse, r7=0.
- STORE r3 -> addr imm=8; LOAD r4 imm=8; ADD r5,r4,r4 immediately after -> instr_ready low exactly one cycle; r4=12, r5=24; retire_count=3 for these.
- LOAD r4 imm=4096 with DMEM_DEPTH=1024 -> reads word 0 (wrap); STORE then LOAD at word 0 returns stored value.
- instr_valid toggled 1,0,1,0 with dependent ADDs -> correct results via MEM/WB forwarding; retire_count counts only valid instructions.
- Reset asserted with 3 instructions in flight -> no wb_valid afterward, all outputs 0, regfile cleared; subsequent ADD r1,r0,r0 yields 0.

Source files
------------

// File: rtl/pipelined_core_fwd.sv
// Four-stage in-order integer pipeline (D/E/M/W) with valid/ready intake, full operand
// forwarding into EX, a one-cycle load-use interlock and a retire counter.
module pipelined_core_fwd #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned DBG_REG    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] result_out,
  output logic [31:0]       retire_count
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned AW = $clog2(DMEM_DEPTH);
  localparam logic [5:0] OpAdd   = 6'd0;
  localparam logic [5:0] OpSub   = 6'd1;
  localparam logic [5:0] OpLoad  = 6'd2;
  localparam logic [5:0] OpStore = 6'd3;
  localparam logic [5:0] OpAddi  = 6'd4;
  localparam logic [RW-1:0] DbgIdx = RW'(DBG_REG);

  logic [DATA_W-1:0] rf_q   [NREGS];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

  logic              ifid_valid_q, ifid_valid_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;

  logic              idex_valid_q, idex_valid_d;
  logic [5:0]        idex_op_q, idex_op_d;
  logic [4:0]        idex_rd_q, idex_rd_d;
  logic [RW-1:0]     idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
  logic [DATA_W-1:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [DATA_W-1:0] idex_s_q, idex_s_d, idex_imm_q, idex_imm_d;

  logic              exmem_valid_q, exmem_valid_d, exmem_we_q, exmem_we_d;
  logic [5:0]        exmem_op_q, exmem_op_d;
  logic [4:0]        exmem_rd_q, exmem_rd_d;
  logic [DATA_W-1:0] exmem_res_q, exmem_res_d, exmem_sdata_q, exmem_sdata_d;
  logic [AW-1:0]     exmem_addr_q, exmem_addr_d;

  logic              memwb_valid_q, memwb_valid_d, memwb_we_q, memwb_we_d;
  logic [4:0]        memwb_rd_q, memwb_rd_d;
  logic [DATA_W-1:0] memwb_data_q, memwb_data_d;

  logic [DATA_W-1:0] result_out_q, result_out_d;
  logic [31:0]       retire_count_q, retire_count_d;

  // Decode-stage signals
  logic [5:0]        id_op;
  logic [RW-1:0]     id_rs1, id_rs2, id_rdi;
  logic              id_use_rs1, id_use_rs2, id_use_rd, stall;

  // Execute / memory-stage signals
  logic              em_fwd_ok, mw_fwd_ok, ex_we;
  logic [DATA_W-1:0] ex_a, ex_b, ex_s, ex_res;
  logic              rf_we, dm_we;
  logic [DATA_W-1:0] m_data;

  function automatic logic [DATA_W-1:0] fwd(
    input logic [RW-1:0]     idx,
    input logic [DATA_W-1:0] cap,
    input logic              em_ok,
    input logic [RW-1:0]     em_idx,
    input logic [DATA_W-1:0] em_val,
    input logic              mw_ok,
    input logic [RW-1:0]     mw_idx,
    input logic [DATA_W-1:0] mw_val
  );
    if (em_ok && em_idx == idx)      return em_val;
    else if (mw_ok && mw_idx == idx) return mw_val;
    else                             return cap;
  endfunction

  always_comb begin
    id_op      = ifid_instr_q[31:26];
    id_rdi     = ifid_instr_q[21 +: RW];
    id_rs1     = ifid_instr_q[16 +: RW];
    id_rs2     = ifid_instr_q[11 +: RW];
    id_use_rs1 = (id_op == OpAdd) || (id_op == OpSub) || (id_op == OpLoad) ||
                 (id_op == OpStore) || (id_op == OpAddi);
    id_use_rs2 = (id_op == OpAdd) || (id_op == OpSub);
    id_use_rd  = (id_op == OpStore);
    // A load in EX cannot forward yet; hold the consumer in ID for one cycle.
    stall = idex_valid_q && (idex_op_q == OpLoad) && (idex_rd_q[RW-1:0] != '0) &&
            ifid_valid_q &&
            ((id_use_rs1 && id_rs1 == idex_rd_q[RW-1:0]) ||
             (id_use_rs2 && id_rs2 == idex_rd_q[RW-1:0]) ||
             (id_use_rd  && id_rdi == idex_rd_q[RW-1:0]));
    instr_ready = !stall;
  end

  always_comb begin
    em_fwd_ok = exmem_valid_q && exmem_we_q && (exmem_op_q != OpLoad) &&
                (exmem_rd_q[RW-1:0] != '0);
    mw_fwd_ok = memwb_valid_q && memwb_we_q && (memwb_rd_q[RW-1:0] != '0);
    ex_a = fwd(idex_rs1_q, idex_a_q, em_fwd_ok, exmem_rd_q[RW-1:0], exmem_res_q,
               mw_fwd_ok, memwb_rd_q[RW-1:0], memwb_data_q);
    ex_b = fwd(idex_rs2_q, idex_b_q, em_fwd_ok, exmem_rd_q[RW-1:0], exmem_res_q,
               mw_fwd_ok, memwb_rd_q[RW-1:0], memwb_data_q);
    ex_s = fwd(idex_rd_q[RW-1:0], idex_s_q, em_fwd_ok, exmem_rd_q[RW-1:0], exmem_res_q,
               mw_fwd_ok, memwb_rd_q[RW-1:0], memwb_data_q);
    case (idex_op_q)
      OpAdd:   ex_res = ex_a + ex_b;
      OpSub:   ex_res = ex_a - ex_b;
      default: ex_res = ex_a + idex_imm_q;
    endcase
    ex_we = (idex_op_q == OpAdd) || (idex_op_q == OpSub) || (idex_op_q == OpLoad) ||
            (idex_op_q == OpAddi);

    m_data = (exmem_op_q == OpLoad) ? dmem_q[exmem_addr_q] : exmem_res_q;
    rf_we  = exmem_valid_q && exmem_we_q && (exmem_rd_q[RW-1:0] != '0);
    dm_we  = exmem_valid_q && (exmem_op_q == OpStore);
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    if (!stall) begin
      ifid_valid_d = instr_valid;
      ifid_instr_d = instr_in;
    end

    idex_valid_d = ifid_valid_q && !stall;
    idex_op_d    = id_op;
    idex_rd_d    = ifid_instr_q[25:21];
    idex_rs1_d   = id_rs1;
    idex_rs2_d   = id_rs2;
    idex_a_d     = rf_q[id_rs1];
    idex_b_d     = rf_q[id_rs2];
    idex_s_d     = rf_q[id_rdi];
    idex_imm_d   = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    exmem_valid_d = idex_valid_q;
    exmem_we_d    = ex_we;
    exmem_op_d    = idex_op_q;
    exmem_rd_d    = idex_rd_q;
    exmem_res_d   = ex_res;
    exmem_sdata_d = ex_s;
    exmem_addr_d  = ex_res[AW+1:2];

    memwb_valid_d = exmem_valid_q;
    memwb_we_d    = exmem_we_q;
    memwb_rd_d    = exmem_rd_q;
    memwb_data_d  = m_data;

    result_out_d   = rf_q[DbgIdx];
    retire_count_d = retire_count_q + {31'd0, memwb_valid_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid_q   <= 1'b0;
      ifid_instr_q   <= '0;
      idex_valid_q   <= 1'b0;
      idex_op_q      <= '0;
      idex_rd_q      <= '0;
      idex_rs1_q     <= '0;
      idex_rs2_q     <= '0;
      idex_a_q       <= '0;
      idex_b_q       <= '0;
      idex_s_q       <= '0;
      idex_imm_q     <= '0;
      exmem_valid_q  <= 1'b0;
      exmem_we_q     <= 1'b0;
      exmem_op_q     <= '0;
      exmem_rd_q     <= '0;
      exmem_res_q    <= '0;
      exmem_sdata_q  <= '0;
      exmem_addr_q   <= '0;
      memwb_valid_q  <= 1'b0;
      memwb_we_q     <= 1'b0;
      memwb_rd_q     <= '0;
      memwb_data_q   <= '0;
      result_out_q   <= '0;
      retire_count_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      ifid_valid_q   <= ifid_valid_d;
      ifid_instr_q   <= ifid_instr_d;
      idex_valid_q   <= idex_valid_d;
      idex_op_q      <= idex_op_d;
      idex_rd_q      <= idex_rd_d;
      idex_rs1_q     <= idex_rs1_d;
      idex_rs2_q     <= idex_rs2_d;
      idex_a_q       <= idex_a_d;
      idex_b_q       <= idex_b_d;
      idex_s_q       <= idex_s_d;
      idex_imm_q     <= idex_imm_d;
      exmem_valid_q  <= exmem_valid_d;
      exmem_we_q     <= exmem_we_d;
      exmem_op_q     <= exmem_op_d;
      exmem_rd_q     <= exmem_rd_d;
      exmem_res_q    <= exmem_res_d;
      exmem_sdata_q  <= exmem_sdata_d;
      exmem_addr_q   <= exmem_addr_d;
      memwb_valid_q  <= memwb_valid_d;
      memwb_we_q     <= memwb_we_d;
      memwb_rd_q     <= memwb_rd_d;
      memwb_data_q   <= memwb_data_d;
      result_out_q   <= result_out_d;
      retire_count_q <= retire_count_d;
      if (rf_we) rf_q[exmem_rd_q[RW-1:0]] <= m_data;
      if (dm_we) dmem_q[exmem_addr_q] <= exmem_sdata_q;
    end
  end

  assign wb_valid     = memwb_valid_q && memwb_we_q;
  assign wb_rd        = memwb_rd_q;
  assign wb_data      = memwb_data_q;
  assign result_out   = result_out_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_pipelined_core_fwd.sv
// Bench for pipelined_core_fwd: an architectural ISA model predicts every writeback,
// which is queued at issue and popped as the core retires.
module tb_pipelined_core_fwd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, result_out, retire_count;

  pipelined_core_fwd #(
    .DATA_W(32), .NREGS(32), .DMEM_DEPTH(1024), .DBG_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .result_out(result_out), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  int          wb_times[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          stall_cyc = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [1024];
  logic [31:0] m_retired;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (!reset && !instr_ready) stall_cyc++;

  // Scoreboard: every retiring register write must match the oldest prediction.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      wb_times.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data)
          $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        else passed++;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs1,
                                        input int rs2);
    return {op, 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int rs1,
                                        input logic [15:0] imm);
    return {op, 5'(rd), 5'(rs1), imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    m_retired = '0;
    exp_q.delete();
  endtask

  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, imm, res, addr;
    logic        wr;
    wb_t         e;
    op   = ins[31:26];
    rd   = ins[25:21];
    rs1  = ins[20:16];
    rs2  = ins[15:11];
    imm  = {{16{ins[15]}}, ins[15:0]};
    a    = m_regs[rs1];
    b    = m_regs[rs2];
    addr = ((a + imm) >> 2) % 1024;
    wr   = 1'b1;
    res  = '0;
    case (op)
      6'd0: res = a + b;
      6'd1: res = a - b;
      6'd2: res = m_mem[addr[9:0]];
      6'd3: begin m_mem[addr[9:0]] = m_regs[rd]; wr = 1'b0; end
      6'd4: res = a + imm;
      default: wr = 1'b0;
    endcase
    if (wr) begin
      e.rd = rd;
      e.data = res;
      exp_q.push_back(e);
      if (rd != 0) m_regs[rd] = res;
    end
    m_retired++;
  endtask

  task automatic issue(input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    instr_in = ins;
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!instr_ready) begin
      total++;
      $display("FAIL issue_timeout: got instr_ready=0 for %0d cycles, required 1", n);
    end else begin
      model_exec(ins);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending writebacks, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    wb_times.delete();
  endtask

  task automatic check_retire(input string name);
    total++;
    if (retire_count !== m_retired)
      $display("FAIL %s_retire: got %0d, required %0d", name, retire_count, m_retired);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0)
      $display("FAIL reset_wb: got valid=%b rd=%0d data=%h, required 0/0/0",
               wb_valid, wb_rd, wb_data);
    else passed++;
    total++;
    if (result_out !== 32'd0) $display("FAIL reset_result: got %h, required 0", result_out);
    else passed++;
    total++;
    if (retire_count !== 32'd0) $display("FAIL reset_retire: got %0d, required 0", retire_count);
    else passed++;
    total++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", instr_ready);
    else passed++;
  endtask

  task automatic test_basic();
    int s0, w0;
    s0 = stall_cyc;
    w0 = wb_times.size();
    issue(enc_i(6'd4, 1, 0, 16'd5));
    issue(enc_i(6'd4, 2, 0, 16'd7));
    issue(enc_r(6'd0, 3, 1, 2));
    drain();
    total++;
    if (stall_cyc - s0 != 0) $display("FAIL basic_stall: got %0d, required 0", stall_cyc - s0);
    else passed++;
    total++;
    if (wb_times.size() - w0 != 3 || wb_times[w0+2] - wb_times[w0] != 2)
      $display("FAIL basic_consecutive: got %0d writebacks, required 3 in consecutive cycles",
               wb_times.size() - w0);
    else passed++;
    total++;
    if (result_out !== 32'd5) $display("FAIL basic_result_out: got %h, required 5", result_out);
    else passed++;
    check_retire("basic");
  endtask

  task automatic test_sub_r0();
    issue(enc_r(6'd1, 6, 1, 2));
    issue(enc_i(6'd4, 0, 0, 16'd9));
    issue(enc_r(6'd0, 7, 0, 0));
    drain();
    total++;
    if (m_regs[6] !== 32'hFFFF_FFFE)
      $display("FAIL sub_model: got %h, required fffffffe", m_regs[6]);
    else passed++;
    check_retire("sub_r0");
  endtask

  task automatic test_store_load();
    int s0;
    logic [31:0] r0c;
    s0  = stall_cyc;
    r0c = retire_count;
    issue(enc_i(6'd3, 3, 0, 16'd8));
    issue(enc_i(6'd2, 4, 0, 16'd8));
    issue(enc_r(6'd0, 5, 4, 4));
    drain();
    total++;
    if (stall_cyc - s0 != 1) $display("FAIL load_use_stall: got %0d, required 1", stall_cyc - s0);
    else passed++;
    total++;
    if (retire_count - r0c !== 32'd3)
      $display("FAIL store_load_retired: got %0d, required 3", retire_count - r0c);
    else passed++;
  endtask

  task automatic test_wrap();
    issue(enc_i(6'd2, 8, 0, 16'd4096));
    issue(enc_i(6'd3, 5, 0, 16'd0));
    issue(enc_i(6'd2, 9, 0, 16'd4096));
    issue(enc_r(6'd0, 10, 9, 8));
    drain();
    check_retire("wrap");
  endtask

  task automatic test_gaps();
    int s0;
    s0 = stall_cyc;
    issue(enc_i(6'd4, 10, 0, 16'd3));
    @(negedge clk);
    issue(enc_r(6'd0, 11, 10, 10));
    @(negedge clk);
    issue(enc_r(6'd0, 12, 11, 10));
    drain();
    total++;
    if (stall_cyc - s0 != 0) $display("FAIL gaps_stall: got %0d, required 0", stall_cyc - s0);
    else passed++;
    check_retire("gaps");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd63};
    for (int k = 0; k < 4; k++) issue(enc_i(6'd4, 13, 13, 16'hFFFF));
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if (op == 6'd2 || op == 6'd3)
        issue(enc_i(op, $urandom_range(0, 7), 0, 16'($urandom_range(0, 31) * 4)));
      else if (op == 6'd4)
        issue(enc_i(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
      else
        issue(enc_r(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    end
    drain();
    check_retire("random");
    total++;
    if (result_out !== m_regs[1])
      $display("FAIL random_result_out: got %h, required %h", result_out, m_regs[1]);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    issue(enc_i(6'd4, 1, 0, 16'd11));
    issue(enc_i(6'd4, 3, 0, 16'd22));
    issue(enc_i(6'd4, 2, 0, 16'd33));
    do_reset();
    #1;
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || result_out !== 32'd0 ||
        retire_count !== 32'd0)
      $display("FAIL midreset_outputs: got valid=%b data=%h result=%h retire=%0d, required 0",
               wb_valid, wb_data, result_out, retire_count);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      if (wb_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL midreset_dropped: got %0d writebacks, required 0", seen);
    else passed++;
    issue(enc_r(6'd0, 1, 0, 0));
    issue(enc_r(6'd0, 14, 3, 3));
    drain();
    check_retire("midreset");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_sub_r0();
    test_store_load();
    test_wrap();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1);
  end

endmodule
